spi_rgb_cmd: RTL
================

// Module: spi_rgb_cmd
// PURPOSE
//   SPI-slave command decoder producing PWM on/off bits for the RGB LED driver's in_r/in_g/in_b.
//   Host clocks a colour frame over SPI (mode 0, MSB first). Decoded 8-bit duties go to shadow registers.
//   Three PWM channels emit glitch-free on/off streams, updated only at PWM period wrap.
// PARAMETERS
//   PWM_DIV   16   clk cycles per PWM count step (>=1); PWM period = 256*PWM_DIV clk
//   CMD_SET   8'h01  command byte: set colour (followed by R,G,B bytes)
//   CMD_OFF   8'h00  command byte: all channels off (no payload)
// PORTS
//   clk          in   1  system clock; must be >= 4x spi_sck frequency
//   rst_n        in   1  asynchronous, active-low reset
//   spi_sck      in   1  SPI clock, async to clk
//   spi_cs_n     in   1  SPI chip select, active low, async
//   spi_mosi     in   1  SPI data in, async
//   out_r        out  1  red PWM on/off bit (feeds LED driver in_r)
//   out_g        out  1  green PWM on/off bit
//   out_b        out  1  blue PWM on/off bit
//   frame_ok     out  1  one-clk pulse: valid frame committed
//   frame_err    out  1  one-clk pulse: malformed frame discarded
// BEHAVIOUR
//   Reset: one clock; reset asynchronous, active-low (rst_n). All outputs 0, duties 0, PWM counters 0, FSM WAIT_IDLE.
//   Sync: sck/cs_n/mosi via 2-FF synchronisers; sck rise detected in clk domain; mosi sampled on rise.
//   Bytes: 3-bit bit counter; byte complete on 8th rise; partial byte discarded when cs_n rises.
//   FSM: WAIT_IDLE -> IDLE when synced cs_n=1 (also exit path after reset with cs_n held low).
//     IDLE -> CMD on cs_n fall; bit/byte counters cleared.
//     CMD: byte==CMD_SET -> DATA(idx=0); byte==CMD_OFF -> TAIL_OFF; other -> DROP.
//     DATA: store R,G,B into staging regs idx 0..2; after B -> TAIL_SET; a 5th byte -> DROP.
//     TAIL_*: any further completed byte -> DROP; cs_n rise -> commit, frame_ok pulse, -> IDLE.
//     DROP: ignore bytes; cs_n rise -> frame_err pulse, -> IDLE.
//     cs_n rise in CMD/DATA, or with partial byte pending in any state -> frame_err, no commit, -> IDLE.
//   Commit: SET copies staging R,G,B to pending duties; OFF sets pending duties to 0.
//   frame_ok/frame_err assert 1 clk after synced cs_n rise; never both in the same cycle.
//   PWM: prescaler 0..PWM_DIV-1; 8-bit count advances when prescaler wraps; shared by all channels.
//     out_x = (count < duty_x), registered. duty 0 -> always 0; duty 255 -> high 255/256 of period.
//     Active duties load from pending only when count==255 and prescaler wraps (period boundary).
//     Commit coinciding with that boundary: new value loads at that boundary.
//   Two commits in one period: last one wins; intermediate value never appears on outputs.
//   Reset mid-frame: everything cleared; rest of in-flight frame ignored until cs_n high seen.
// STRUCTURE
//   Package spi_rgb_pkg: CMD_SET/CMD_OFF constants, FSM state enum, DUTY_W=8, channel index constants.
//   Sub-module spi_byte_rx: synchronisers, edge detect, shift reg, bit counter;
//     outputs byte_valid/byte_data, cs_fall, cs_rise, partial.
//   Top: command FSM, staging/pending/active duty registers, shared prescaler + counter,
//     three comparators.
// TESTING
//   1. Frame 01 FF 00 80 (sck=clk/8) -> frame_ok 1 clk after cs_n rise; next period out_r high 255,
//      out_g 0, out_b 128 of 256 steps.
//   2. Frame 00 after colour set -> frame_ok; from next period boundary out_r/g/b constant 0.
//   3. Frame 01 10 20 (3 bytes) -> frame_err; outputs keep previous duties unchanged.
//   4. Frame 7E 11 22 33 -> frame_err; 01 11 22 33 44 -> frame_err; no duty change either case.
//   5. Frame 01 40 40 40 then 12 extra sck pulses before cs_n rise -> frame_err (partial byte).
//   6. Assert rst_n low mid-frame with cs_n low, release, finish frame -> no frame_ok/err;
//      a following full frame 01 01 02 03 -> frame_ok.
//   7. Commit issued at count==255 prescaler wrap -> new duty visible exactly at next count 0;
//      two commits in one period -> only last value observed.

Source files
------------

// File: rtl/spi_rgb_pkg.sv
// spi_rgb_pkg: shared constants and types for the SPI RGB command decoder.
//   CMD_SET / CMD_OFF : default command byte encodings
//   cmd_state_e       : command FSM states
//   DUTY_W, duty_t    : PWM duty width and type
//   CH_R/CH_G/CH_B    : channel indices into duty arrays
package spi_rgb_pkg;

    localparam int unsigned DUTY_W  = 8;
    localparam logic [7:0]  CMD_SET = 8'h01;
    localparam logic [7:0]  CMD_OFF = 8'h00;

    localparam int unsigned CH_R   = 0;
    localparam int unsigned CH_G   = 1;
    localparam int unsigned CH_B   = 2;
    localparam int unsigned NUM_CH = 3;

    typedef logic [DUTY_W-1:0] duty_t;

    typedef enum logic [2:0] {
        WAIT_IDLE,
        IDLE,
        CMD,
        DATA,
        TAIL_SET,
        TAIL_OFF,
        DROP
    } cmd_state_e;

endpackage

// File: rtl/spi_rgb_cmd_if.sv
// spi_rgb_cmd_if: SPI slave pins plus PWM/status outputs of spi_rgb_cmd.
//   master : drives spi_sck/spi_cs_n/spi_mosi, observes outputs (host side)
//   slave  : receives SPI pins, drives out_r/g/b, frame_ok, frame_err (decoder side)
interface spi_rgb_cmd_if;

    logic spi_sck;
    logic spi_cs_n;
    logic spi_mosi;
    logic out_r;
    logic out_g;
    logic out_b;
    logic frame_ok;
    logic frame_err;

    modport master (
        output spi_sck, spi_cs_n, spi_mosi,
        input  out_r, out_g, out_b, frame_ok, frame_err
    );

    modport slave (
        input  spi_sck, spi_cs_n, spi_mosi,
        output out_r, out_g, out_b, frame_ok, frame_err
    );

endinterface

// File: rtl/spi_byte_rx.sv
// spi_byte_rx: SPI mode-0 byte receiver in the clk domain.
//   clk, rst_n        : system clock, async active-low reset
//   sck_i/cs_n_i/mosi_i : raw asynchronous SPI pins
//   byte_valid_o      : one-clk pulse, byte_data_o holds a completed byte (MSB first)
//   cs_fall_o/cs_rise_o : one-clk pulses on synchronised chip-select edges
//   partial_o         : bits of an incomplete byte are pending
module spi_byte_rx
    import spi_rgb_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  sck_i,
    input  logic  cs_n_i,
    input  logic  mosi_i,
    output logic  byte_valid_o,
    output duty_t byte_data_o,
    output logic  cs_fall_o,
    output logic  cs_rise_o,
    output logic  partial_o
);

    logic [1:0] sck_sync_q, cs_sync_q, mosi_sync_q;
    logic       sck_prev_q, cs_prev_q;
    logic [2:0] bit_cnt_q;
    duty_t      shift_q, byte_data_q;
    logic       byte_valid_q;
    logic       sck_s, cs_s, mosi_s, sck_rise;

    assign sck_s    = sck_sync_q[1];
    assign cs_s     = cs_sync_q[1];
    assign mosi_s   = mosi_sync_q[1];
    assign sck_rise = sck_s & ~sck_prev_q & ~cs_s;

    // Synchronisers reset to "selected" (0) so a frame in flight across reset
    // is never mistaken for a fresh cs_n fall; a real cs_n high is required first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync_q   <= '0;
            cs_sync_q    <= '0;
            mosi_sync_q  <= '0;
            sck_prev_q   <= 1'b0;
            cs_prev_q    <= 1'b0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            byte_data_q  <= '0;
            byte_valid_q <= 1'b0;
        end else begin
            sck_sync_q   <= {sck_sync_q[0], sck_i};
            cs_sync_q    <= {cs_sync_q[0], cs_n_i};
            mosi_sync_q  <= {mosi_sync_q[0], mosi_i};
            sck_prev_q   <= sck_s;
            cs_prev_q    <= cs_s;
            byte_valid_q <= 1'b0;
            if (cs_s) begin
                bit_cnt_q <= '0;
            end else if (sck_rise) begin
                shift_q   <= {shift_q[DUTY_W-2:0], mosi_s};
                bit_cnt_q <= bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    byte_valid_q <= 1'b1;
                    byte_data_q  <= {shift_q[DUTY_W-2:0], mosi_s};
                end
            end
        end
    end

    assign byte_valid_o = byte_valid_q;
    assign byte_data_o  = byte_data_q;
    assign cs_fall_o    = ~cs_s & cs_prev_q;
    assign cs_rise_o    = cs_s & ~cs_prev_q;
    assign partial_o    = (bit_cnt_q != 3'd0);

endmodule

// File: rtl/spi_rgb_cmd.sv
// spi_rgb_cmd: SPI colour-frame decoder driving three PWM on/off outputs.
//   clk, rst_n : system clock (>= 4x spi_sck), async active-low reset
//   bus        : slave modport -- spi_sck/spi_cs_n/spi_mosi in;
//                out_r/out_g/out_b PWM bits, frame_ok/frame_err one-clk pulses out
// Frames: CMD_SET R G B sets the colour, CMD_OFF blanks all channels. Committed
// duties wait in pending registers and reach the PWM only at a period boundary.
module spi_rgb_cmd #(
    parameter int unsigned PWM_DIV = 16,
    parameter logic [7:0]  CMD_SET = spi_rgb_pkg::CMD_SET,
    parameter logic [7:0]  CMD_OFF = spi_rgb_pkg::CMD_OFF
) (
    input logic          clk,
    input logic          rst_n,
    spi_rgb_cmd_if.slave bus
);

    import spi_rgb_pkg::*;

    localparam int unsigned PSC_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;

    logic       byte_valid, cs_fall, cs_rise, partial;
    duty_t      byte_data;

    cmd_state_e state_q;
    logic [1:0] idx_q;
    logic       frame_ok_q, frame_err_q;

    duty_t [NUM_CH-1:0] stage_q, pend_q, pend_d, act_q, act_d;
    logic  [PSC_W-1:0]  psc_q, psc_d;
    duty_t              cnt_q, cnt_d;
    logic  [NUM_CH-1:0] out_q, out_d;
    logic               commit_set, commit_off, psc_wrap, boundary;

    spi_byte_rx u_rx (
        .clk         (clk),
        .rst_n       (rst_n),
        .sck_i       (bus.spi_sck),
        .cs_n_i      (bus.spi_cs_n),
        .mosi_i      (bus.spi_mosi),
        .byte_valid_o(byte_valid),
        .byte_data_o (byte_data),
        .cs_fall_o   (cs_fall),
        .cs_rise_o   (cs_rise),
        .partial_o   (partial)
    );

    // Commit is decided combinationally so a commit landing on the period
    // boundary is forwarded straight into the active duties at that edge.
    always_comb begin
        commit_set = cs_rise && !partial && (state_q == TAIL_SET);
        commit_off = cs_rise && !partial && (state_q == TAIL_OFF);
        psc_wrap   = (psc_q == PSC_W'(PWM_DIV - 1));
        psc_d      = psc_wrap ? '0 : psc_q + PSC_W'(1);
        cnt_d      = psc_wrap ? cnt_q + 8'd1 : cnt_q;
        boundary   = psc_wrap && (cnt_q == '1);
        pend_d     = pend_q;
        act_d      = act_q;
        out_d      = '0;
        for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
            if (commit_set)      pend_d[ch] = stage_q[ch];
            else if (commit_off) pend_d[ch] = '0;
            if (boundary)        act_d[ch]  = pend_d[ch];
            // Compare next count with next duty so the registered output
            // lines up with the count value it belongs to.
            out_d[ch] = (cnt_d < act_d[ch]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= WAIT_IDLE;
            idx_q       <= '0;
            stage_q     <= '0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            case (state_q)
                WAIT_IDLE: if (cs_rise) state_q <= IDLE;
                IDLE: begin
                    if (cs_fall) begin
                        state_q <= CMD;
                        idx_q   <= '0;
                    end
                end
                default: begin
                    if (cs_rise) begin
                        state_q <= IDLE;
                        if ((state_q == TAIL_SET || state_q == TAIL_OFF) && !partial)
                            frame_ok_q <= 1'b1;
                        else
                            frame_err_q <= 1'b1;
                    end else if (byte_valid) begin
                        case (state_q)
                            CMD: begin
                                if (byte_data == CMD_SET) begin
                                    state_q <= DATA;
                                    idx_q   <= '0;
                                end else if (byte_data == CMD_OFF) begin
                                    state_q <= TAIL_OFF;
                                end else begin
                                    state_q <= DROP;
                                end
                            end
                            DATA: begin
                                stage_q[idx_q] <= byte_data;
                                if (idx_q == 2'd2) state_q <= TAIL_SET;
                                else               idx_q   <= idx_q + 2'd1;
                            end
                            default: state_q <= DROP;
                        endcase
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
            act_q  <= '0;
            psc_q  <= '0;
            cnt_q  <= '0;
            out_q  <= '0;
        end else begin
            pend_q <= pend_d;
            act_q  <= act_d;
            psc_q  <= psc_d;
            cnt_q  <= cnt_d;
            out_q  <= out_d;
        end
    end

    assign bus.out_r     = out_q[CH_R];
    assign bus.out_g     = out_q[CH_G];
    assign bus.out_b     = out_q[CH_B];
    assign bus.frame_ok  = frame_ok_q;
    assign bus.frame_err = frame_err_q;

endmodule
